// File: rtl/usb_debug_dma_if.sv
// Bus bundle between usb_debug_dma and its control, memory and USB FIFO peers.
interface usb_debug_dma_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  dma_start;
  logic [3:0]            dma_bank;
  logic [ADDR_WIDTH-1:0] dma_address;
  logic [19:0]           dma_length;
  logic                  abort;
  logic                  dma_busy;
  logic                  mem_request;
  logic [3:0]            mem_bank;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_busy;
  logic                  mem_ack;
  logic [31:0]           mem_data;
  logic                  fifo_write;
  logic [7:0]            fifo_data;
  logic                  fifo_full;

  modport master (
    input  dma_start, dma_bank, dma_address, dma_length, abort,
    input  mem_busy, mem_ack, mem_data, fifo_full,
    output dma_busy, mem_request, mem_bank, mem_address,
    output fifo_write, fifo_data
  );

  modport slave (
    output dma_start, dma_bank, dma_address, dma_length, abort,
    output mem_busy, mem_ack, mem_data, fifo_full,
    input  dma_busy, mem_request, mem_bank, mem_address,
    input  fifo_write, fifo_data
  );
endinterface

// File: rtl/usb_debug_dma.sv
// Word-read DMA streaming memory data to the USB TX FIFO byte by byte.
// USB_DEBUG_DMA_BYTE_SWAP_EN selects LSB-first byte order (default MSB first).
module usb_debug_dma #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic            i_clk,
  input  logic            i_reset,
  usb_debug_dma_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT_ACK,
    SEND
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [19:0]           len_q;
  logic [31:0]           shreg_q;
  logic [1:0]            byte_q;
  logic                  drop_q, drop_d;
  logic                  load, capture, push, accept;

  assign accept = (state_q == REQUEST) && !bus.mem_busy;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    load    = 1'b0;
    capture = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.abort && bus.dma_start && bus.dma_length != 20'd0) begin
          load    = 1'b1;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        // An accepted request must still collect its ack, even if aborted.
        if (accept) begin
          state_d = WAIT_ACK;
          drop_d  = bus.abort;
        end else if (bus.abort) begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        if (bus.mem_ack) begin
          drop_d = 1'b0;
          if (drop_q || bus.abort) begin
            state_d = IDLE;
          end else begin
            capture = 1'b1;
            state_d = SEND;
          end
        end else if (bus.abort) begin
          drop_d = 1'b1;
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.fifo_full) begin
          push = 1'b1;
          if (byte_q == 2'd3)
            state_d = (len_q == 20'd1) ? IDLE : REQUEST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (load) begin
        bank_q <= bus.dma_bank;
        addr_q <= bus.dma_address;
        len_q  <= bus.dma_length;
      end
      if (capture) begin
        shreg_q <= bus.mem_data;
        byte_q  <= 2'd0;
      end
      if (push) begin
        byte_q <= byte_q + 2'd1;
`ifdef USB_DEBUG_DMA_BYTE_SWAP_EN
        shreg_q <= {8'h00, shreg_q[31:8]};
`else
        shreg_q <= {shreg_q[23:0], 8'h00};
`endif
        if (byte_q == 2'd3) begin
          addr_q <= addr_q + 1'b1;
          len_q  <= len_q - 20'd1;
        end
      end
    end
  end

`ifdef USB_DEBUG_DMA_BYTE_SWAP_EN
  assign bus.fifo_data = shreg_q[7:0];
`else
  assign bus.fifo_data = shreg_q[31:24];
`endif
  assign bus.fifo_write  = push;
  assign bus.dma_busy    = (state_q != IDLE);
  assign bus.mem_request = (state_q == REQUEST);
  assign bus.mem_bank    = bank_q;
  assign bus.mem_address = addr_q;
endmodule
